// File: rtl/pipe_src_arbiter.sv
// Round-robin scheduler that merges N_SRC strobed sample sources onto one pipeline input.
// Optional overwrite counter: define ARB_DROP_CNT_EN to build drop_cnt_out logic.
module pipe_src_arbiter #(
  parameter int unsigned          N_SRC        = 8,
  parameter int unsigned          W_SRC        = 5,
  parameter int unsigned          W_DIN        = 18,
  parameter int unsigned          W_WR_ADDR    = 16,
  parameter int unsigned          W_WR_DATA    = 48,
  parameter logic [W_WR_ADDR-1:0] ADDR_SRC_EN  = 16'h0040,
  parameter logic [W_WR_ADDR-1:0] ADDR_OVF_CLR = 16'h0041,
  parameter logic [N_SRC-1:0]     EN_RST       = '1
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [N_SRC-1:0]       src_dv_in,
  input  logic [N_SRC*W_DIN-1:0] src_data_in,
  input  logic                   pipe_ready_in,
  input  logic                   wr_en,
  input  logic [W_WR_ADDR-1:0]   wr_addr,
  input  logic [W_WR_DATA-1:0]   wr_data,
  output logic                   dv_out,
  output logic [W_SRC-1:0]       src_out,
  output logic [W_DIN-1:0]       data_out,
  output logic [N_SRC-1:0]       ovf_out,
  output logic [15:0]            drop_cnt_out
);

  logic [N_SRC-1:0] en_mask_q, en_mask_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] ovf_q, ovf_d;
  logic [W_SRC-1:0] rr_q, rr_d;
  logic [W_DIN-1:0] hold_q [N_SRC];

  logic             dv_q;
  logic [W_SRC-1:0] src_q;
  logic [W_DIN-1:0] data_q;

  logic             en_wr, clr_wr;
  logic [N_SRC-1:0] keep_mask, clr_mask;
  logic [N_SRC-1:0] elig, elig_hi;
  logic [N_SRC-1:0] cap, overwrite, grant_oh;
  logic             grant_vld;
  logic [W_SRC-1:0] grant_idx;
  logic [W_DIN-1:0] grant_data;

  assign en_wr     = wr_en && (wr_addr == ADDR_SRC_EN);
  assign clr_wr    = wr_en && (wr_addr == ADDR_OVF_CLR);
  // A source disabled this cycle loses its pending sample and cannot be granted or captured.
  assign keep_mask = en_wr  ? wr_data[N_SRC-1:0] : {N_SRC{1'b1}};
  assign clr_mask  = clr_wr ? wr_data[N_SRC-1:0] : {N_SRC{1'b0}};
  assign elig      = pending_q & keep_mask;

  if (W_WR_DATA > N_SRC) begin : g_wr_data_unused
    logic unused_wr_data;
    assign unused_wr_data = ^wr_data[W_WR_DATA-1:N_SRC];
  end

  // Round-robin pick: lowest eligible index at or above rr, else lowest eligible overall.
  always_comb begin
    elig_hi = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      elig_hi[i] = elig[i] && (i >= int'(rr_q));
    end

    grant_vld = pipe_ready_in && (|elig);
    grant_idx = '0;
    if (|elig_hi) begin
      for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
        if (elig_hi[i]) grant_idx = W_SRC'(i);
      end
    end else begin
      for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
        if (elig[i]) grant_idx = W_SRC'(i);
      end
    end

    grant_oh   = '0;
    grant_data = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (grant_vld && (grant_idx == W_SRC'(i))) begin
        grant_oh[i] = 1'b1;
        grant_data  = hold_q[i];
      end
    end
  end

  always_comb begin
    cap       = src_dv_in & en_mask_q & keep_mask;
    // Granted source re-strobed in the same cycle is a refill, not an overwrite.
    overwrite = cap & pending_q & ~grant_oh;
    pending_d = ((pending_q & ~grant_oh) | cap) & keep_mask;
    ovf_d     = (ovf_q & ~clr_mask) | overwrite;
    en_mask_d = en_wr ? wr_data[N_SRC-1:0] : en_mask_q;

    rr_d = rr_q;
    if (grant_vld) begin
      rr_d = (grant_idx == W_SRC'(N_SRC - 1)) ? '0 : grant_idx + W_SRC'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      en_mask_q <= EN_RST;
      pending_q <= '0;
      ovf_q     <= '0;
      rr_q      <= '0;
      dv_q      <= 1'b0;
      src_q     <= '0;
      data_q    <= '0;
    end else begin
      en_mask_q <= en_mask_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      rr_q      <= rr_d;
      dv_q      <= grant_vld;
      if (grant_vld) begin
        src_q  <= grant_idx;
        data_q <= grant_data;
      end
    end
  end

  // Sample storage needs no reset: pending_q gates every use.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (cap[i]) hold_q[i] <= src_data_in[i*W_DIN +: W_DIN];
    end
  end

  assign dv_out   = dv_q;
  assign src_out  = src_q;
  assign data_out = data_q;
  assign ovf_out  = ovf_q;

`ifdef ARB_DROP_CNT_EN
  localparam int unsigned W_INC = $clog2(N_SRC + 1);

  logic [W_INC-1:0] drop_inc;
  logic [16:0]      drop_sum;
  logic [15:0]      drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_inc = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      drop_inc = drop_inc + W_INC'(overwrite[i]);
    end
    drop_sum = {1'b0, drop_cnt_q} + 17'(drop_inc);
    if (clr_wr) begin
      drop_cnt_d = 16'(drop_inc);
    end else if (drop_sum[16]) begin
      drop_cnt_d = 16'hFFFF;
    end else begin
      drop_cnt_d = drop_sum[15:0];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt_out = drop_cnt_q;
`else
  assign drop_cnt_out = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_src_arbiter.sv
// Self-checking bench for pipe_src_arbiter: directed scenarios plus random traffic,
// all checked against a queue-free behavioural model of the scheduling rules.
module tb_pipe_src_arbiter;

  localparam int N  = 8;
  localparam int WS = 5;
  localparam int WD = 18;
  localparam int WA = 16;
  localparam int WW = 48;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    src_dv;
  logic [N*WD-1:0] src_data;
  logic            ready;
  logic            wr_en;
  logic [WA-1:0]   wr_addr;
  logic [WW-1:0]   wr_data;
  logic            dv;
  logic [WS-1:0]   src;
  logic [WD-1:0]   data;
  logic [N-1:0]    ovf;
  logic [15:0]     drop;

  always #5 clk = ~clk;

  pipe_src_arbiter #(
    .N_SRC    (N),
    .W_SRC    (WS),
    .W_DIN    (WD),
    .W_WR_ADDR(WA),
    .W_WR_DATA(WW)
  ) dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .src_dv_in    (src_dv),
    .src_data_in  (src_data),
    .pipe_ready_in(ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .dv_out       (dv),
    .src_out      (src),
    .data_out     (data),
    .ovf_out      (ovf),
    .drop_cnt_out (drop)
  );

  // Reference model state
  logic [N-1:0]  m_pend;
  logic [WD-1:0] m_hold [N];
  logic [N-1:0]  m_en;
  logic [N-1:0]  m_ovf;
  int            m_cnt;
  int            m_rr;
  logic          m_dv;
  int            m_src;
  logic [WD-1:0] m_data;
  int            issue_cnt [N];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [N-1:0] keep, clr;
    int g, drops;
    if (rst) begin
      m_pend = '0; m_en = '1; m_ovf = '0; m_cnt = 0; m_rr = 0;
      m_dv = 1'b0; m_src = 0; m_data = '0;
      return;
    end
    keep = (wr_en && wr_addr == 16'h0040) ? wr_data[N-1:0] : '1;
    clr  = (wr_en && wr_addr == 16'h0041) ? wr_data[N-1:0] : '0;
    g = -1;
    if (ready) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_rr + k) % N;
        if (m_pend[idx] && keep[idx]) begin
          g = idx;
          break;
        end
      end
    end
    if (g >= 0) begin
      m_dv = 1'b1; m_src = g; m_data = m_hold[g];
      m_rr = (g + 1) % N;
      m_pend[g] = 1'b0;
    end else begin
      m_dv = 1'b0;
    end
    m_ovf = m_ovf & ~clr;
    drops = 0;
    for (int i = 0; i < N; i++) begin
      if (src_dv[i] && m_en[i] && keep[i]) begin
        if (m_pend[i]) begin
          drops++;
          m_ovf[i] = 1'b1;
        end
        m_hold[i] = src_data[i*WD +: WD];
        m_pend[i] = 1'b1;
      end
    end
    m_pend = m_pend & keep;
    if (wr_en && wr_addr == 16'h0040) m_en = wr_data[N-1:0];
`ifdef ARB_DROP_CNT_EN
    if (wr_en && wr_addr == 16'h0041) m_cnt = drops;
    else m_cnt = (m_cnt + drops > 65535) ? 65535 : m_cnt + drops;
`else
    m_cnt = 0;
`endif
  endtask

  // Evaluate the model on the current inputs, clock once, compare, then drop one-shot inputs.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("dv", 64'(dv), 64'(m_dv));
    check("src", 64'(src), 64'(m_src));
    check("data", 64'(data), 64'(m_data));
    check("ovf", 64'(ovf), 64'(m_ovf));
    check("drop_cnt", 64'(drop), 64'(m_cnt));
    if (dv) issue_cnt[src]++;
    src_dv = '0;
    wr_en  = 1'b0;
  endtask

  task automatic set_src(input int i, input logic [WD-1:0] d);
    src_dv[i] = 1'b1;
    src_data[i*WD +: WD] = d;
  endtask

  task automatic cfg_write(input logic [WA-1:0] a, input logic [WW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; src_dv = '0; src_data = '0; ready = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < N; i++) begin
      issue_cnt[i] = 0;
      m_hold[i] = '0;
    end
    cycle();
    cycle();
    check("rst_dv", 64'(dv), 64'd0);
    rst = 1'b0;

    // 1: single-sample latency
    ready = 1'b1;
    set_src(3, 18'h1ABCD);
    cycle();
    check("t1_idle", 64'(dv), 64'd0);
    cycle();
    check("t1_dv", 64'(dv), 64'd1);
    check("t1_src", 64'(src), 64'd3);
    check("t1_data", 64'(data), 64'h1ABCD);
    cycle();
    check("t1_dv_off", 64'(dv), 64'd0);

    // 2: round-robin order from rr=0, then from rr=3
    do_reset();
    set_src(0, 18'h00100); set_src(2, 18'h00102); set_src(5, 18'h00105);
    cycle();
    cycle(); check("t2_first", 64'(src), 64'd0);
    cycle(); check("t2_second", 64'(src), 64'd2);
    cycle(); check("t2_third", 64'(src), 64'd5);
    set_src(2, 18'h00202);
    cycle();
    cycle(); check("t2_rr3", 64'(src), 64'd2);
    set_src(0, 18'h00300); set_src(5, 18'h00305);
    cycle();
    cycle(); check("t2_wrap_a", 64'(src), 64'd5);
    cycle(); check("t2_wrap_b", 64'(src), 64'd0);

    // 3: overwrite while stalled, then W1C clear
    ready = 1'b0;
    set_src(1, 18'd10);
    cycle();
    set_src(1, 18'd20);
    cycle();
    check("t3_ovf", 64'(ovf[1]), 64'd1);
    ready = 1'b1;
    cycle();
    check("t3_issue", 64'(dv), 64'd1);
    check("t3_newest", 64'(data), 64'd20);
    cycle();
    check("t3_single", 64'(dv), 64'd0);
    cfg_write(16'h0041, 48'h2);
    cycle();
    check("t3_ovf_clr", 64'(ovf), 64'd0);

    // 4: disable a pending source
    ready = 1'b0;
    set_src(2, 18'd7);
    cycle();
    cfg_write(16'h0040, 48'hFB);
    cycle();
    ready = 1'b1;
    repeat (3) cycle();
    check("t4_dropped", 64'(dv), 64'd0);
    set_src(2, 18'd9);
    cycle();
    cycle();
    check("t4_ignored", 64'(dv), 64'd0);
    cfg_write(16'h0040, 48'hFF);
    cycle();
    set_src(2, 18'd11);
    cycle();
    cycle();
    check("t4_reen_src", 64'(src), 64'd2);
    check("t4_reen_data", 64'(data), 64'd11);

    // 5: fairness under full load
    do_reset();
    for (int c = 0; c < 66; c++) begin
      for (int i = 0; i < N; i++) set_src(i, WD'($urandom));
      cycle();
      if (c == 1) begin
        for (int i = 0; i < N; i++) issue_cnt[i] = 0;
      end
    end
    for (int i = 0; i < N; i++) check($sformatf("t5_fair_%0d", i), 64'(issue_cnt[i]), 64'd8);
    repeat (N + 2) cycle();

    // 6: reset with samples pending, then rr and enable mask back to defaults
    ready = 1'b1;
    set_src(4, 18'd44);
    cycle();
    cycle();
    ready = 1'b0;
    set_src(1, 18'd1); set_src(3, 18'd3); set_src(6, 18'd6); set_src(7, 18'd7);
    cycle();
    cfg_write(16'h0040, 48'h0F);
    cycle();
    do_reset();
    ready = 1'b1;
    repeat (3) begin
      cycle();
      check("t6_quiet", 64'(dv), 64'd0);
    end
    check("t6_outs", 64'({src, data, ovf}), 64'd0);
    set_src(6, 18'd66); set_src(1, 18'd11);
    cycle();
    cycle(); check("t6_rr0", 64'(src), 64'd1);
    cycle(); check("t6_en_rst", 64'(src), 64'd6);

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      rst   = ($urandom_range(0, 199) == 0);
      ready = ($urandom_range(0, 3) != 0);
      src_dv = N'($urandom & $urandom);
      for (int i = 0; i < N; i++) src_data[i*WD +: WD] = WD'($urandom);
      if ($urandom_range(0, 11) == 0) begin
        case ($urandom_range(0, 2))
          0:       cfg_write(16'h0040, 48'($urandom | $urandom));
          1:       cfg_write(16'h0041, 48'($urandom));
          default: cfg_write(16'h0042, 48'($urandom));
        endcase
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
